// File: rtl/march_ctrl_if.sv
// March C- controller bus: start request, RAM port and status flags.
// master = controller side, slave = environment (RAM model / sequencer).
interface march_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3
);
  logic              start;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_wdata;
  logic              acc_en;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;

  modport master (
    input  start, ram_rdata,
    output ram_addr, ram_we, ram_re, ram_wdata, acc_en, busy, done, fail, fail_addr
  );

  modport slave (
    output start, ram_rdata,
    input  ram_addr, ram_we, ram_re, ram_wdata, acc_en, busy, done, fail, fail_addr
  );
endinterface

// File: rtl/march_ctrl.sv
// March C- memory test sequencer.
// Elements: M0 up{w0}, M1 up{r0,w1}, M2 up{r1,w0}, M3 down{r0,w1},
// M4 down{r1,w0}, M5 down{r0}, then one DRAIN cycle for the last read's data.
// All bus outputs are registered from the next-state decode.
// Optional macro MARCH_CTRL_CMP_EN enables the inline read comparator that
// drives fail/fail_addr; without it those outputs are tied to zero.
module march_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  march_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    M0    = 4'd1,
    M1    = 4'd2,
    M2    = 4'd3,
    M3    = 4'd4,
    M4    = 4'd5,
    M5    = 4'd6,
    DRAIN = 4'd7,
    DONE  = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              op;         // 0 = read slot, 1 = write slot of a two-op element

  state_t            nxt_state;
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_op;
  logic              nxt_we;
  logic              nxt_re;
  logic              nxt_ones;   // write data is all ones
  logic              nxt_march;  // next state is one of M0..M5

  // Next-state and address sequencing for the March elements.
  always_comb begin
    nxt_state = state;
    nxt_addr  = addr;
    nxt_op    = op;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          nxt_state = M0;
          nxt_addr  = '0;
          nxt_op    = 1'b0;
        end else begin
          nxt_state = state;
        end
      end
      M0: begin
        if (addr == LAST) begin
          nxt_state = M1;
          nxt_addr  = '0;
        end else begin
          nxt_addr = addr + ONE;
        end
      end
      M1, M2: begin
        if (!op) begin
          nxt_op = 1'b1;
        end else begin
          nxt_op = 1'b0;
          if (addr == LAST) begin
            nxt_state = (state == M1) ? M2 : M3;
            nxt_addr  = (state == M1) ? '0 : LAST;
          end else begin
            nxt_addr = addr + ONE;
          end
        end
      end
      M3, M4: begin
        if (!op) begin
          nxt_op = 1'b1;
        end else begin
          nxt_op = 1'b0;
          if (addr == '0) begin
            nxt_state = (state == M3) ? M4 : M5;
            nxt_addr  = LAST;
          end else begin
            nxt_addr = addr - ONE;
          end
        end
      end
      M5: begin
        if (addr == '0) begin
          nxt_state = DRAIN;
        end else begin
          nxt_addr = addr - ONE;
        end
      end
      DRAIN: begin
        nxt_state = DONE;
        nxt_addr  = '0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_addr  = '0;
        nxt_op    = 1'b0;
      end
    endcase
  end

  // Decode the RAM strobes and write data for the state being entered.
  always_comb begin
    nxt_we    = 1'b0;
    nxt_re    = 1'b0;
    nxt_ones  = 1'b0;
    nxt_march = 1'b0;
    case (nxt_state)
      M0: begin
        nxt_we    = 1'b1;
        nxt_march = 1'b1;
      end
      M1, M3: begin
        nxt_we    = nxt_op;
        nxt_re    = ~nxt_op;
        nxt_ones  = nxt_op;
        nxt_march = 1'b1;
      end
      M2, M4: begin
        nxt_we    = nxt_op;
        nxt_re    = ~nxt_op;
        nxt_march = 1'b1;
      end
      M5: begin
        nxt_re    = 1'b1;
        nxt_march = 1'b1;
      end
      default: begin
        nxt_we    = 1'b0;
        nxt_re    = 1'b0;
      end
    endcase
  end

  // Controller FSM with registered bus outputs; acc_en trails ram_re by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      op            <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_re    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.acc_en    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= nxt_state;
      addr          <= nxt_addr;
      op            <= nxt_op;
      bus.ram_addr  <= nxt_march ? nxt_addr : '0;
      bus.ram_we    <= nxt_we;
      bus.ram_re    <= nxt_re;
      bus.ram_wdata <= (nxt_we && nxt_ones) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      bus.acc_en    <= bus.ram_re;
      bus.busy      <= nxt_march || (nxt_state == DRAIN);
      bus.done      <= (nxt_state == DONE);
    end
  end

`ifdef MARCH_CTRL_CMP_EN
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_exp;

  // Capture address and expected value of the read in flight, compare when data returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr       <= '0;
      rd_exp        <= '0;
      bus.fail      <= 1'b0;
      bus.fail_addr <= '0;
    end else begin
      if (bus.ram_re) begin
        rd_addr <= bus.ram_addr;
        rd_exp  <= ((state == M2) || (state == M4)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      end else begin
        rd_addr <= rd_addr;
      end
      if (bus.start && ((state == IDLE) || (state == DONE))) begin
        bus.fail      <= 1'b0;
        bus.fail_addr <= '0;
      end else if (bus.acc_en && !bus.fail && (bus.ram_rdata != rd_exp)) begin
        bus.fail      <= 1'b1;
        bus.fail_addr <= rd_addr;
      end else begin
        bus.fail      <= bus.fail;
      end
    end
  end
`else
  assign bus.fail      = 1'b0;
  assign bus.fail_addr = '0;
`endif

endmodule

// File: tb/tb_march_ctrl.sv
// Scoreboard bench for march_ctrl: expected RAM operations are queued when a
// test is started, a negedge monitor pops and compares every DUT operation.
module tb_march_ctrl;

`ifdef MARCH_CTRL_CMP_EN
  localparam int CMP = 1;
`else
  localparam int CMP = 0;
`endif

  logic clk;
  logic reset;

  march_ctrl_if #(.ADDR_W(3), .DATA_W(3)) bus ();

  march_ctrl #(.ADDR_W(3), .DATA_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_total = 0;
  int acc_base  = 0;
  int ops_seen  = 0;
  bit fault_en  = 1'b0;
  bit fail_seen = 1'b0;
  bit prev_re   = 1'b0;
  logic [7:0] sb[$];          // {we, re, addr[2:0], wdata[2:0]}
  logic [2:0] mem [8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // RAM model: registered read, optional stuck-at-0 on bit 1 of address 5
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) begin
      if (fault_en && bus.ram_addr == 3'd5) bus.ram_rdata <= mem[bus.ram_addr] & 3'b101;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // Expected March C- operation list for one full test (8 words)
  task automatic push_seq();
    logic [2:0] a;
    logic [2:0] rv;
    for (int i = 0; i < 8; i++) sb.push_back({1'b1, 1'b0, 3'(i), 3'b000});
    for (int e = 1; e <= 4; e++) begin
      rv = (e == 2 || e == 4) ? 3'b111 : 3'b000;
      for (int i = 0; i < 8; i++) begin
        a = (e <= 2) ? 3'(i) : 3'(7 - i);
        sb.push_back({1'b0, 1'b1, a, 3'b000});
        sb.push_back({1'b1, 1'b0, a, ~rv});
      end
    end
    for (int i = 0; i < 8; i++) sb.push_back({1'b0, 1'b1, 3'(7 - i), 3'b000});
  endtask

  // Monitor: protocol rules every cycle, scoreboard pop on every RAM operation
  always @(negedge clk) begin
    logic [7:0] exp_op;
    if (!reset) begin
      prev_re = 1'b0;
    end else begin
      check("we_re_exclusive", int'(bus.ram_we && bus.ram_re), 0);
      if (!bus.ram_we) check("wdata_zero_no_we", int'(bus.ram_wdata), 0);
      if (!bus.busy) check("idle_quiet", int'({bus.ram_addr, bus.ram_we, bus.ram_re, bus.acc_en}), 0);
      check("acc_en_follows_re", int'(bus.acc_en), int'(prev_re));
      prev_re = bus.ram_re;
      if (bus.acc_en) acc_total++;
      if (bus.ram_we || bus.ram_re) begin
        ops_seen++;
        check("busy_during_op", int'(bus.busy), 1);
        if (sb.size() == 0) begin
          check("unexpected_op", int'({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata}), -1);
        end else begin
          exp_op = sb.pop_front();
          check("op", int'({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata}), int'(exp_op));
        end
      end
      if (CMP == 0) begin
        check("fail_tied", int'({bus.fail, bus.fail_addr}), 0);
      end else if (!bus.fail) begin
        fail_seen = 1'b0;
      end else begin
        if (!fail_seen) begin
          fail_seen = 1'b1;
          check("fail_only_with_fault", int'(fault_en), 1);
          check("fail_after_m2_r1_addr5", acc_total - acc_base, 14);
        end
        check("fail_addr_hold", int'(bus.fail_addr), 5);
      end
    end
  end

  // Queue a test and pulse start; returns at the negedge of the first M0 cycle
  task automatic kick(input int n_seq, input bit hold);
    @(posedge clk); #2;
    for (int k = 0; k < n_seq; k++) push_seq();
    acc_base  = acc_total;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = hold;
    @(negedge clk);
    check("m0_busy", int'(bus.busy), 1);
    check("m0_done_clear", int'(bus.done), 0);
    check("m0_fail_clear", int'(bus.fail), 0);
  endtask

  task automatic wait_done(input int first, output int cyc);
    cyc = first;
    while (!bus.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int acc_snap;
    clk = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 3'b000;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", int'({bus.ram_addr, bus.ram_we, bus.ram_re, bus.ram_wdata,
                                 bus.acc_en, bus.busy, bus.done, bus.fail, bus.fail_addr}), 0);
    reset = 1'b1;

    // fault-free run
    kick(1, 1'b0);
    wait_done(1, cyc);
    check("clean_done_cycle", cyc, 82);
    check("clean_acc_count", acc_total - acc_base, 40);
    check("clean_fail", int'(bus.fail), 0);
    check("clean_busy_low", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    check("done_level_held", int'(bus.done), 1);

    // stuck-at-0 at address 5 bit 1
    fault_en = 1'b1;
    kick(1, 1'b0);
    wait_done(1, cyc);
    check("fault_done_cycle", cyc, 82);
    check("fault_acc_count", acc_total - acc_base, 40);
    check("fault_fail", int'(bus.fail), CMP);
    check("fault_fail_addr", int'(bus.fail_addr), CMP * 5);
    fault_en = 1'b0;

    // start held high: no restart while busy, immediate restart from DONE
    kick(2, 1'b1);
    wait_done(1, cyc);
    check("held_done_cycle", cyc, 82);
    check("held_acc_count", acc_total - acc_base, 40);
    acc_base = acc_total;
    @(negedge clk);
    check("restart_done_clear", int'(bus.done), 0);
    check("restart_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    wait_done(1, cyc);
    check("restart_done_cycle", cyc, 82);
    check("restart_acc_count", acc_total - acc_base, 40);

    // reset for one cycle in the middle of M3
    kick(1, 1'b0);
    cyc = 0;
    while (ops_seen < 40 + 45 * 0 && cyc < 0) cyc++;
    acc_snap = ops_seen;
    cyc = 0;
    while (ops_seen - acc_snap < 44 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("reached_m3", int'(bus.ram_addr <= 3'd7 && bus.busy), 1);
    reset = 1'b0;
    #1;
    check("midreset_outputs", int'({bus.ram_addr, bus.ram_we, bus.ram_re, bus.ram_wdata,
                                    bus.acc_en, bus.busy, bus.done, bus.fail, bus.fail_addr}), 0);
    sb.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    acc_snap = acc_total;
    repeat (20) @(negedge clk);
    check("no_acc_after_reset", acc_total - acc_snap, 0);
    check("no_done_after_reset", int'(bus.done), 0);
    kick(1, 1'b0);
    wait_done(1, cyc);
    check("post_reset_done_cycle", cyc, 82);
    check("post_reset_acc_count", acc_total - acc_base, 40);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
